// File: rtl/load_store_unit_pkg.sv
// Shared RISC-V defines (widths, LSU size and FSM encodings) and the LSU package.
// Pure declarations: no logic, no latency, no flow control.
`ifndef RISC_V_DEFINES
`define RISC_V_DEFINES
`define REG_WIDTH        32
`define DMEM_ADDR_WIDTH  10
`define DMEM_DEPTH       1024
`define LSU_SIZE_B       2'b00
`define LSU_SIZE_H       2'b01
`define LSU_SIZE_W       2'b10
`define LSU_ST_IDLE      2'b00
`define LSU_ST_RD        2'b01
`define LSU_ST_WR        2'b10
`define LSU_ST_RESP      2'b11
`endif

package load_store_unit_pkg;

    localparam logic [1:0] LSU_SIZE_B  = `LSU_SIZE_B;
    localparam logic [1:0] LSU_SIZE_H  = `LSU_SIZE_H;
    localparam logic [1:0] LSU_SIZE_W  = `LSU_SIZE_W;

    localparam logic [1:0] ST_IDLE     = `LSU_ST_IDLE;
    localparam logic [1:0] ST_RD       = `LSU_ST_RD;
    localparam logic [1:0] ST_WR       = `LSU_ST_WR;
    localparam logic [1:0] ST_RESP     = `LSU_ST_RESP;

    // Reserved size 2'b11 behaves as a word access.
    function automatic logic [2:0] lsu_access_bytes(input logic [1:0] size);
        case (size)
            LSU_SIZE_B: lsu_access_bytes = 3'd1;
            LSU_SIZE_H: lsu_access_bytes = 3'd2;
            default:    lsu_access_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_mux.sv
// Byte-lane merge for sub-word stores and lane extract/extend for loads.
// Purely combinational, zero latency, no flow control.
module lsu_lane_mux
    import load_store_unit_pkg::*;
#(
    parameter int REG_WIDTH = `REG_WIDTH
) (
    input  logic [1:0]           i_size,
    input  logic                 i_unsigned,
    input  logic [1:0]           i_lane,
    input  logic [REG_WIDTH-1:0] i_word,
    input  logic [REG_WIDTH-1:0] i_wdata,
    output logic [REG_WIDTH-1:0] o_merged,
    output logic [REG_WIDTH-1:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_merged = i_word;
        o_load   = '0;
        w_byte   = i_word[{i_lane, 3'b000} +: 8];
        w_half   = i_word[{i_lane[1], 4'b0000} +: 16];
        case (i_size)
            LSU_SIZE_B: begin
                o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
                o_load = i_unsigned ? {{(REG_WIDTH-8){1'b0}}, w_byte}
                                    : {{(REG_WIDTH-8){w_byte[7]}}, w_byte};
            end
            LSU_SIZE_H: begin
                o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
                o_load = i_unsigned ? {{(REG_WIDTH-16){1'b0}}, w_half}
                                    : {{(REG_WIDTH-16){w_half[15]}}, w_half};
            end
            default: begin
                o_merged = i_wdata;
                o_load   = i_word;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: 1 request in flight, response 1 (error), 2 (load/word store) or 3 (sub-word store) cycles after accept.
// req_ready only in IDLE; the one-cycle response strobe cannot be backpressured.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int REG_WIDTH       = `REG_WIDTH,
    parameter int DMEM_ADDR_WIDTH = `DMEM_ADDR_WIDTH,
    parameter int DMEM_DEPTH      = `DMEM_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [1:0]                 req_size,
    input  logic                       req_unsigned,
    input  logic [REG_WIDTH-1:0]       req_addr,
    input  logic [REG_WIDTH-1:0]       req_wdata,
    output logic                       rsp_valid,
    output logic [REG_WIDTH-1:0]       rsp_rdata,
    output logic                       rsp_misalign,
    output logic                       rsp_range,
    output logic                       dmem_wr_en,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [REG_WIDTH-1:0]       dmem_wr_data,
    input  logic [REG_WIDTH-1:0]       dmem_rdata
);

    localparam logic [REG_WIDTH:0] DEPTH_EXT = (REG_WIDTH+1)'(DMEM_DEPTH);

    logic [1:0]                 r_state;
    logic                       r_we;
    logic [1:0]                 r_size;
    logic                       r_unsigned;
    logic [DMEM_ADDR_WIDTH-1:0] r_addr;
    logic [REG_WIDTH-1:0]       r_wdata;
    logic                       r_misalign;
    logic                       r_range;
    logic [REG_WIDTH-1:0]       r_word;

    logic                       w_accept;
    logic                       w_misalign;
    logic                       w_range;
    logic [REG_WIDTH:0]         w_end;
    logic [REG_WIDTH-1:0]       w_merged;
    logic [REG_WIDTH-1:0]       w_load;

    assign w_accept   = req_valid && (r_state == ST_IDLE);
    assign w_misalign = (req_size == LSU_SIZE_H) ? req_addr[0]
                                                 : (req_size[1] && (req_addr[1:0] != 2'b00));
    // One extra bit so an address near the top of the register range cannot wrap.
    assign w_end      = {1'b0, req_addr} + (REG_WIDTH+1)'(lsu_access_bytes(req_size));
    assign w_range    = w_end > DEPTH_EXT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_misalign <= 1'b0;
            r_range    <= 1'b0;
            r_word     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr[DMEM_ADDR_WIDTH-1:0];
                        r_wdata    <= req_wdata;
                        r_misalign <= w_misalign;
                        r_range    <= w_range;
                        if (w_misalign || w_range)
                            r_state <= ST_RESP;
                        else if (req_we && req_size[1])
                            r_state <= ST_WR;
                        else
                            r_state <= ST_RD;
                    end
                end
                ST_RD: begin
                    r_word  <= dmem_rdata;
                    r_state <= r_we ? ST_WR : ST_RESP;
                end
                ST_WR:   r_state <= ST_RESP;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    lsu_lane_mux #(
        .REG_WIDTH (REG_WIDTH)
    ) u_lane_mux (
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .i_lane     (r_addr[1:0]),
        .i_word     (r_word),
        .i_wdata    (r_wdata),
        .o_merged   (w_merged),
        .o_load     (w_load)
    );

    // Everything below decodes registered state only; req_* never reaches dmem_*.
    always_comb begin
        req_ready    = (r_state == ST_IDLE);
        dmem_wr_en   = 1'b0;
        dmem_addr    = '0;
        dmem_wr_data = '0;
        rsp_valid    = 1'b0;
        rsp_rdata    = '0;
        rsp_misalign = 1'b0;
        rsp_range    = 1'b0;
        case (r_state)
            ST_RD: dmem_addr = {r_addr[DMEM_ADDR_WIDTH-1:2], 2'b00};
            ST_WR: begin
                dmem_addr    = {r_addr[DMEM_ADDR_WIDTH-1:2], 2'b00};
                dmem_wr_en   = 1'b1;
                dmem_wr_data = r_size[1] ? r_wdata : w_merged;
            end
            ST_RESP: begin
                rsp_valid    = 1'b1;
                rsp_misalign = r_misalign;
                rsp_range    = r_range;
                if (!r_we && !r_misalign && !r_range)
                    rsp_rdata = w_load;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter REG_WIDTH, default `REG_WIDTH (32), the data and address width on the pipeline side.
REQ-002 The block SHALL have parameter DMEM_ADDR_WIDTH, default `DMEM_ADDR_WIDTH, the DMEM byte-address width.
REQ-003 The block SHALL have parameter DMEM_DEPTH, default `DMEM_DEPTH, the DMEM size in bytes.
REQ-004 Ports SHALL be, in this order (name, direction, width, meaning):
clk  in  1  clock; all state updates on posedge
reset_n  in  1  reset, asynchronous, active-low
req_valid  in  1  pipeline presents a request
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  REG_WIDTH  byte address
req_wdata  in  REG_WIDTH  store data, right-aligned
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  REG_WIDTH  extended load data; 0 for stores and errors
rsp_misalign  out  1  half not 2-aligned or word not 4-aligned; valid with rsp_valid
rsp_range  out  1  req_addr+access_bytes > DMEM_DEPTH; valid with rsp_valid
dmem_wr_en  out  1  DMEM write enable
dmem_addr  out  DMEM_ADDR_WIDTH  DMEM word-aligned byte address
dmem_wr_data  out  REG_WIDTH  DMEM little-endian write word
dmem_rdata  in  REG_WIDTH  DMEM read word; valid by the posedge ending the cycle it is addressed with dmem_wr_en=0

Function
REQ-005 The FSM SHALL have states IDLE, RD, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-006 On accept, the block SHALL latch req_we, req_size, req_unsigned, req_addr, req_wdata, and the error flags.
REQ-007 Transitions from IDLE on accept SHALL be: error -> RESP; load -> RD; word store -> WR; byte/half store -> RD.
REQ-008 Transitions from RD SHALL be: load -> RESP; sub-word store -> WR; WR -> RESP; RESP -> IDLE unconditionally.
REQ-009 dmem_addr SHALL be {latched_addr[DMEM_ADDR_WIDTH-1:2],2'b00} in RD and WR, and 0 otherwise.
REQ-010 dmem_wr_en SHALL be 1 only in WR; dmem_wr_data SHALL be 0 outside WR.
REQ-011 All dmem_* outputs SHALL be decoded from state and latched registers only, with no combinational path from req_* inputs.
REQ-012 In RD, the block SHALL capture dmem_rdata into a word register at the posedge leaving RD.
REQ-013 In WR, a word store SHALL write the latched data unchanged.
REQ-014 In WR, a sub-word store SHALL write the captured word with only the addressed lanes replaced: byte lane = addr[1:0], half lanes = addr[1]*2 and addr[1]*2+1.
REQ-015 For loads, rsp_rdata SHALL be the addressed lanes of the captured word, shifted to bit 0, then zero- or sign-extended to REG_WIDTH.
REQ-016 rsp_valid, rsp_rdata, rsp_misalign and rsp_range SHALL be driven only in RESP and SHALL be 0 otherwise; there is no response backpressure.
REQ-017 Latency from the accept edge to rsp_valid high SHALL be: error 1 cycle; load 2 cycles; word store 2 cycles; sub-word store 3 cycles.
REQ-018 An erroring request SHALL never assert dmem_wr_en; when both errors are present, both flags SHALL assert.
REQ-019 Back-to-back requests SHALL be accepted at the earliest in the cycle after RESP, i.e. in IDLE.

Reset
REQ-020 While reset_n is low, the block SHALL force state IDLE, clear all latched and captured registers to 0, and hold all outputs at 0 except req_ready=1.
REQ-021 Reset asserted in any state SHALL abort the access immediately: dmem_wr_en falls asynchronously, no response is issued, and no partial write occurs after the reset edge.

Structure
REQ-022 The size encodings LSU_SIZE_B/H/W and the FSM state encodings SHALL be defined in the shared risc_v_defines include alongside REG_WIDTH, DMEM_ADDR_WIDTH and DMEM_DEPTH.
REQ-023 Lane merge (store) and lane extract/extend (load) SHALL be one combinational sub-module, lsu_lane_mux, instantiated once.

Verification
REQ-024 The bench SHALL cover: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata 0xDEADBEEF; each rsp_valid 2 cycles after accept.
REQ-025 The bench SHALL cover: SB 0xA5 @0x13 -> RD then WR, rsp_valid at 3 cycles, DMEM word 0xA5ADBEEF; then LB @0x13 -> 0xFFFFFFA5 and LBU @0x13 -> 0x000000A5.
REQ-026 The bench SHALL cover: SH 0x1234 @0x12 -> word 0x1234BEEF; LH @0x12 -> 0x00001234; LH @0x11 -> rsp_misalign=1 at 1 cycle, rsp_rdata 0, dmem_wr_en never 1.
REQ-027 The bench SHALL cover: LW @DMEM_DEPTH-2 -> rsp_misalign=1 and rsp_range=1; SB @DMEM_DEPTH-1 -> no error, write performed.
REQ-028 The bench SHALL cover: req_valid held high for 3 LW requests -> req_ready low in RD/RESP, accepts spaced 3 cycles apart, 3 rsp_valid pulses.
REQ-029 The bench SHALL cover: reset_n pulsed low during WR of an SB -> dmem_wr_en drops at once, no rsp_valid, and after release req_ready=1 and the DMEM word is unchanged by the aborted write.
